bldc_commutator: RTL and testbench
==================================

# bldc_commutator

Six-step commutation controller for one brushless motor. Filters the three hall-sensor inputs and sequences three phase drivers, one per motor phase, by setting each driver's duty cycle and high-impedance control. Also ramp-limits commanded duty, handles direction reversal through a timed coast, and latches faults for invalid hall codes and rotor stall. Sits between the motor-command register bank and the three phase drivers.

## Interface
- DUTY_WIDTH, 9: width of duty command and per-phase duty outputs
- HALL_FILTER, 4: consecutive stable cycles before a hall code is accepted (≥1)
- RAMP_DIV, 256: cycles per +1 duty step when ramping up (≥1)
- COAST_CYCLES, 50000: all-phases-floating time on direction change
- STALL_CYCLES, 1000000: cycles without hall change that count as a stall

- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run request; low forces IDLE
- direction  in  1  0 = forward, 1 = reverse
- duty_cmd  in  DUTY_WIDTH  commanded duty
- hall  in  3  raw hall sensors {c,b,a}, asynchronous
- duty_a, duty_b, duty_c  out  DUTY_WIDTH  per-phase duty to drivers
- high_z_a, high_z_b, high_z_c  out  1  per-phase float
- fault  out  1  latched fault
- fault_cause  out  2  01 invalid hall, 10 stall, 00 none
- comm_count  out  16  accepted hall transitions in RUN, wraps

## Operation
- Hall path: 2-flop synchronizer, then filter. Filtered code updates once the synchronized value has been unchanged for HALL_FILTER cycles. Filtered code resets to 000.
- Valid codes 001..110; 000/111 invalid.
- Forward drive map (high/low/float): 001 A/B/C, 011 A/C/B, 010 B/C/A, 110 B/A/C, 100 C/A/B, 101 C/B/A. Reverse swaps high and low phases.
- High phase: duty = applied duty, high_z 0.
- Low phase: duty 0, high_z 0.
- Float phase: duty 0, high_z 1.
- Ramp, applied duty:
  - If duty_cmd < applied: applied takes duty_cmd the next cycle.
  - If duty_cmd > applied: +1 every RAMP_DIV cycles, never overshoots.
  - Cleared to 0 outside RUN.
- States:
  - IDLE: all high_z 1, duties 0. enable=1 with valid filtered code goes to RUN; with invalid code goes to FAULT (cause 01).
  - RUN: drive map applied. Invalid filtered code goes to FAULT (01). Stall goes to FAULT (10). Any change of synchronized direction goes to COAST.
  - COAST: all high_z 1. After COAST_CYCLES goes to RUN, with ramp starting from 0. A direction change during COAST restarts the count.
  - FAULT: all high_z 1, fault 1, cause held. Exits only via enable=0 to IDLE, which clears fault and cause.
- Priority, same cycle: enable=0 > invalid hall > stall > direction change.
- comm_count increments on each filtered-code change while in RUN. Wraps 0xFFFF→0. Not cleared by IDLE; cleared only by reset.

## Timing
- Reset (async assert, synchronous-release by upstream): state IDLE, all high_z 1, all duties 0, fault 0, fault_cause 00, comm_count 0, applied duty 0, filtered hall 000.
- Hall change to outputs: 2 sync + HALL_FILTER + 1 output register = 7 cycles at defaults.
- All outputs are registered; no combinational input→output path.
- enable, direction: 2-flop synchronized. Transition effects appear on outputs 3 cycles after the input edge.
- Filter glitch shorter than HALL_FILTER cycles: no change.
- Commutation is applied directly between valid codes, without an intermediate float cycle.

## Configuration
- STALL_DETECT_EN defined:
  - Stall counter runs in RUN while applied duty ≠ 0.
  - It clears on each filtered-code change and whenever applied duty = 0.
  - Reaching STALL_CYCLES goes to FAULT (10).
- STALL_DETECT_EN undefined: no counter logic; cause 10 is never produced.

## Test plan
- Reset, enable=0 → all high_z 1, duties 0, fault 0, comm_count 0.
- hall=001, enable=1, direction=0, duty_cmd=100, RAMP_DIV=4 → A high, B low, C float. duty_a reaches 100 after 400 cycles. Step duty_cmd to 20 → duty_a=20 next output cycle.
- Forward hall sequence 001,011,010,110,100,101, each held 20 cycles → drive map matches for every code, comm_count=5. A 2-cycle glitch injected mid-sequence → no change.
- Toggle direction in RUN → all float for COAST_CYCLES, then reverse map with ramp restarting at 0.
- hall=111 in RUN → fault 1, cause 01 within 7 cycles. Hold enable=1 → stays FAULT. enable=0 → IDLE, fault 0.
- STALL_DETECT_EN, STALL_CYCLES=1000, duty 50, hall frozen → fault, cause 10 at 1000 cycles. Same with duty_cmd=0 → no fault.

Source files
------------

// File: rtl/bldc_commutator_if.sv
// bldc_commutator_if: signal bundle between the motor-command register bank
// (master) and the six-step commutation controller (slave).
//   enable, direction, duty_cmd   : run request, rotation sense, commanded duty
//   hall                          : raw hall sensors {c,b,a}, asynchronous
//   duty_a/b/c, high_z_a/b/c      : per-phase duty and float control to drivers
//   fault, fault_cause            : latched fault and its cause
//   comm_count                    : accepted hall transitions while running
interface bldc_commutator_if #(
   parameter int DUTY_WIDTH = 9
);
   logic                  enable;
   logic                  direction;
   logic [DUTY_WIDTH-1:0] duty_cmd;
   logic [2:0]            hall;
   logic [DUTY_WIDTH-1:0] duty_a;
   logic [DUTY_WIDTH-1:0] duty_b;
   logic [DUTY_WIDTH-1:0] duty_c;
   logic                  high_z_a;
   logic                  high_z_b;
   logic                  high_z_c;
   logic                  fault;
   logic [1:0]            fault_cause;
   logic [15:0]           comm_count;

   modport master (
      output enable, direction, duty_cmd, hall,
      input  duty_a, duty_b, duty_c, high_z_a, high_z_b, high_z_c,
             fault, fault_cause, comm_count
   );

   modport slave (
      input  enable, direction, duty_cmd, hall,
      output duty_a, duty_b, duty_c, high_z_a, high_z_b, high_z_c,
             fault, fault_cause, comm_count
   );
endinterface

// File: rtl/bldc_commutator.sv
// bldc_commutator: six-step commutation controller for one brushless motor.
// Filters the hall sensors, maps the hall code to high/low/float phases,
// ramp-limits the commanded duty, coasts on direction reversal and latches
// faults for invalid hall codes (cause 01) and rotor stall (cause 10).
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : bldc_commutator_if.slave (command inputs, phase/fault outputs)
// Build option: define STALL_DETECT_EN to include the stall counter; without
// it no stall logic is built and cause 10 never occurs.
module bldc_commutator #(
   parameter int DUTY_WIDTH   = 9,
   parameter int HALL_FILTER  = 4,
   parameter int RAMP_DIV     = 256,
   parameter int COAST_CYCLES = 50000,
   parameter int STALL_CYCLES = 1000000
) (
   input logic              clock,
   input logic              reset_n,
   bldc_commutator_if.slave bus
);

   localparam int HF_W = $clog2(HALL_FILTER + 1);
   localparam logic [HF_W-1:0] HF_MAX = HF_W'(HALL_FILTER);
   localparam int RD_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [RD_W-1:0] RD_LAST = RD_W'(RAMP_DIV - 1);
   localparam int CC_W = (COAST_CYCLES > 1) ? $clog2(COAST_CYCLES) : 1;
   localparam logic [CC_W-1:0] CC_LAST = CC_W'(COAST_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, COAST, FAULT} state_t;
   state_t state, state_n;

   logic [2:0]            hall_s1, hall_s2, hall_last, hall_filt, hall_prev;
   logic [HF_W-1:0]       hf_cnt, hf_cnt_n;
   logic                  en_s1, en_s2, dir_s1, dir_s2, dir_prev;
   logic [DUTY_WIDTH-1:0] applied, applied_n;
   logic [RD_W-1:0]       ramp_cnt, ramp_cnt_n;
   logic [CC_W-1:0]       coast_cnt, coast_cnt_n;
   logic [1:0]            cause, cause_n;
   logic [2:0]            hi_oh, lo_oh;   // one-hot {c,b,a}
   logic                  hall_valid, hall_chg, dir_chg, stall;

   assign hall_valid = (hall_filt != 3'b000) && (hall_filt != 3'b111);
   assign hall_chg   = (hall_filt != hall_prev);
   assign dir_chg    = (dir_s2 != dir_prev);

   // Stable-cycle count of the synchronized hall value; the count of the
   // cycle being closed is used so the filtered code lands HALL_FILTER
   // cycles after the synchronizer output settles.
   always_comb begin
      hf_cnt_n = hf_cnt;
      if (hall_s2 != hall_last)
         hf_cnt_n = HF_W'(1);
      else if (hf_cnt < HF_MAX)
         hf_cnt_n = hf_cnt + 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hall_s1   <= '0;
         hall_s2   <= '0;
         hall_last <= '0;
         hf_cnt    <= '0;
         hall_filt <= '0;
         hall_prev <= '0;
         en_s1     <= 1'b0;
         en_s2     <= 1'b0;
         dir_s1    <= 1'b0;
         dir_s2    <= 1'b0;
         dir_prev  <= 1'b0;
      end else begin
         hall_s1   <= bus.hall;
         hall_s2   <= hall_s1;
         hall_last <= hall_s2;
         hf_cnt    <= hf_cnt_n;
         if (hf_cnt_n >= HF_MAX)
            hall_filt <= hall_s2;
         hall_prev <= hall_filt;
         en_s1     <= bus.enable;
         en_s2     <= en_s1;
         dir_s1    <= bus.direction;
         dir_s2    <= dir_s1;
         dir_prev  <= dir_s2;
      end
   end

`ifdef STALL_DETECT_EN
   localparam int SC_W = $clog2(STALL_CYCLES + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STALL_CYCLES);
   logic [SC_W-1:0] stall_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         stall_cnt <= '0;
      else if (state != RUN || applied == '0 || hall_chg)
         stall_cnt <= '0;
      else if (stall_cnt < SC_MAX)
         stall_cnt <= stall_cnt + 1'b1;
   end

   always_comb stall = (stall_cnt >= SC_MAX);
`else
   // Detection not built; STALL_CYCLES only keeps the parameter list intact.
   always_comb stall = (STALL_CYCLES < 0);
`endif

   // Next state; priority enable > invalid hall > stall > direction change.
   always_comb begin
      state_n     = state;
      cause_n     = cause;
      coast_cnt_n = '0;
      case (state)
         IDLE: begin
            cause_n = 2'b00;
            if (en_s2) begin
               if (hall_valid) state_n = RUN;
               else begin
                  state_n = FAULT;
                  cause_n = 2'b01;
               end
            end
         end
         RUN: begin
            if (!en_s2) state_n = IDLE;
            else if (!hall_valid) begin
               state_n = FAULT;
               cause_n = 2'b01;
            end else if (stall) begin
               state_n = FAULT;
               cause_n = 2'b10;
            end else if (dir_chg) state_n = COAST;
         end
         COAST: begin
            if (!en_s2) state_n = IDLE;
            else if (dir_chg) coast_cnt_n = '0;
            else if (coast_cnt == CC_LAST) state_n = RUN;
            else coast_cnt_n = coast_cnt + 1'b1;
         end
         FAULT: begin
            if (!en_s2) begin
               state_n = IDLE;
               cause_n = 2'b00;
            end
         end
         default: begin
            state_n = IDLE;
            cause_n = 2'b00;
         end
      endcase
   end

   // Ramp: drops follow immediately, rises step once per RAMP_DIV cycles.
   always_comb begin
      applied_n  = applied;
      ramp_cnt_n = '0;
      if (state_n != RUN)
         applied_n = '0;
      else if (bus.duty_cmd < applied)
         applied_n = bus.duty_cmd;
      else if (bus.duty_cmd > applied) begin
         if (ramp_cnt == RD_LAST) applied_n = applied + 1'b1;
         else ramp_cnt_n = ramp_cnt + 1'b1;
      end
   end

   // Forward drive map; reverse swaps high and low phases.
   always_comb begin
      hi_oh = 3'b000;
      lo_oh = 3'b000;
      case (hall_filt)
         3'b001: begin hi_oh = 3'b001; lo_oh = 3'b010; end
         3'b011: begin hi_oh = 3'b001; lo_oh = 3'b100; end
         3'b010: begin hi_oh = 3'b010; lo_oh = 3'b100; end
         3'b110: begin hi_oh = 3'b010; lo_oh = 3'b001; end
         3'b100: begin hi_oh = 3'b100; lo_oh = 3'b001; end
         3'b101: begin hi_oh = 3'b100; lo_oh = 3'b010; end
         default: ;
      endcase
      if (dir_s2) begin
         hi_oh = hi_oh ^ lo_oh;
         lo_oh = hi_oh ^ lo_oh;
         hi_oh = hi_oh ^ lo_oh;
      end
   end

   // Outputs are registered from next-state values so input effects land on
   // the same edge as the state change.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         cause           <= 2'b00;
         coast_cnt       <= '0;
         applied         <= '0;
         ramp_cnt        <= '0;
         bus.duty_a      <= '0;
         bus.duty_b      <= '0;
         bus.duty_c      <= '0;
         bus.high_z_a    <= 1'b1;
         bus.high_z_b    <= 1'b1;
         bus.high_z_c    <= 1'b1;
         bus.fault       <= 1'b0;
         bus.fault_cause <= 2'b00;
         bus.comm_count  <= '0;
      end else begin
         state           <= state_n;
         cause           <= cause_n;
         coast_cnt       <= coast_cnt_n;
         applied         <= applied_n;
         ramp_cnt        <= ramp_cnt_n;
         bus.fault       <= (state_n == FAULT);
         bus.fault_cause <= cause_n;
         if (state_n == RUN) begin
            bus.duty_a   <= hi_oh[0] ? applied_n : '0;
            bus.duty_b   <= hi_oh[1] ? applied_n : '0;
            bus.duty_c   <= hi_oh[2] ? applied_n : '0;
            bus.high_z_a <= ~(hi_oh[0] | lo_oh[0]);
            bus.high_z_b <= ~(hi_oh[1] | lo_oh[1]);
            bus.high_z_c <= ~(hi_oh[2] | lo_oh[2]);
         end else begin
            bus.duty_a   <= '0;
            bus.duty_b   <= '0;
            bus.duty_c   <= '0;
            bus.high_z_a <= 1'b1;
            bus.high_z_b <= 1'b1;
            bus.high_z_c <= 1'b1;
         end
         // Only transitions onto a valid code count as commutations.
         if (state == RUN && hall_chg && hall_valid)
            bus.comm_count <= bus.comm_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_bldc_commutator.sv
module tb_bldc_commutator;
   localparam int DW = 9;
   localparam int HF = 4;
   localparam int RD = 4;
   localparam int CC = 40;
   localparam int SC = 1000;
   localparam int VW = 3*DW + 3 + 1 + 2 + 16;
   localparam logic [VW-1:0] M_ALL = '1;

   typedef struct {
      int             due;
      logic [8*16-1:0] tag;
      logic [VW-1:0]  exp;
      logic [VW-1:0]  mask;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb[$];

   bldc_commutator_if #(.DUTY_WIDTH(DW)) bus();

   bldc_commutator #(
      .DUTY_WIDTH(DW), .HALL_FILTER(HF), .RAMP_DIV(RD),
      .COAST_CYCLES(CC), .STALL_CYCLES(SC)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_eq(input logic [8*16-1:0] tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %0s @cyc %0d: got %h, expected %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [VW-1:0] outs_now();
      return {bus.duty_a, bus.duty_b, bus.duty_c, bus.high_z_a, bus.high_z_b,
              bus.high_z_c, bus.fault, bus.fault_cause, bus.comm_count};
   endfunction

   // Reference outputs from the drive table: phase 0=A, 1=B, 2=C.
   function automatic logic [VW-1:0] model(input logic [2:0] code, input logic dir, input int duty,
                                           input logic run, input logic flt, input logic [1:0] cause,
                                           input int comm);
      int hi, lo, t;
      logic [DW-1:0] d [3];
      logic hz [3];
      hi = 0; lo = 0;
      case (code)
         3'b001: begin hi = 0; lo = 1; end
         3'b011: begin hi = 0; lo = 2; end
         3'b010: begin hi = 1; lo = 2; end
         3'b110: begin hi = 1; lo = 0; end
         3'b100: begin hi = 2; lo = 0; end
         3'b101: begin hi = 2; lo = 1; end
         default: run = 1'b0;
      endcase
      if (dir) begin t = hi; hi = lo; lo = t; end
      for (int p = 0; p < 3; p++) begin d[p] = '0; hz[p] = 1'b1; end
      if (run) begin
         d[hi] = DW'(duty);
         hz[hi] = 1'b0;
         hz[lo] = 1'b0;
      end
      return {d[0], d[1], d[2], hz[0], hz[1], hz[2], flt, cause, 16'(comm)};
   endfunction

   task automatic expect_at(input int due, input logic [8*16-1:0] tag, input logic [VW-1:0] e, input logic [VW-1:0] m);
      exp_t it;
      int i;
      it.due = due; it.tag = tag; it.exp = e; it.mask = m;
      i = 0;
      while (i < sb.size() && sb[i].due <= due) i++;
      sb.insert(i, it);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Scoreboard consumer: compares every expectation on its due cycle.
   always @(negedge clock) begin
      exp_t it;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         it = sb.pop_front();
         check_eq(it.tag, outs_now() & it.mask, it.exp & it.mask);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, e, p, q, comm;
      logic [2:0] prev;
      logic [2:0] codes [5];
      codes[0] = 3'b011; codes[1] = 3'b010; codes[2] = 3'b110;
      codes[3] = 3'b100; codes[4] = 3'b101;

      bus.enable = 1'b0; bus.direction = 1'b0; bus.duty_cmd = '0; bus.hall = 3'b001;
      #1 reset_n = 1'b0;
      #2 check_eq("reset", outs_now(), model(3'b001, 1'b0, 0, 1'b0, 1'b0, 2'b00, 0));
      tick(3);
      reset_n = 1'b1;
      tick(12);
      check_eq("idle", outs_now(), model(3'b001, 1'b0, 0, 1'b0, 1'b0, 2'b00, 0));

      // Enable and ramp to 100: applied after RUN-entry edge E+k = (k+1)/RD
      n = cyc; bus.duty_cmd = 100; bus.enable = 1'b1; e = n + 3;
      expect_at(e,       "run_entry", model(3'b001, 1'b0, 0,   1'b1, 1'b0, 2'b00, 0), M_ALL);
      expect_at(e + 100, "ramp_25",   model(3'b001, 1'b0, 25,  1'b1, 1'b0, 2'b00, 0), M_ALL);
      expect_at(e + 398, "ramp_99",   model(3'b001, 1'b0, 99,  1'b1, 1'b0, 2'b00, 0), M_ALL);
      expect_at(e + 399, "ramp_100",  model(3'b001, 1'b0, 100, 1'b1, 1'b0, 2'b00, 0), M_ALL);
      expect_at(e + 450, "ramp_hold", model(3'b001, 1'b0, 100, 1'b1, 1'b0, 2'b00, 0), M_ALL);
      tick(e + 460 - n);

      n = cyc; bus.duty_cmd = 20;
      expect_at(n + 1, "duty_step", model(3'b001, 1'b0, 20, 1'b1, 1'b0, 2'b00, 0), M_ALL);
      tick(5);

      // Forward sequence, each code held 20 cycles; glitch during 010
      comm = 0; prev = 3'b001;
      for (int i = 0; i < 5; i++) begin
         n = cyc; bus.hall = codes[i];
         expect_at(n + 6, "hall_old", model(prev, 1'b0, 20, 1'b1, 1'b0, 2'b00, comm), M_ALL);
         comm++;
         expect_at(n + 7, "hall_new", model(codes[i], 1'b0, 20, 1'b1, 1'b0, 2'b00, comm), M_ALL);
         if (i == 1) begin
            tick(10);
            expect_at(cyc + 9, "glitch", model(3'b010, 1'b0, 20, 1'b1, 1'b0, 2'b00, comm), M_ALL);
            bus.hall = 3'b000;
            tick(2);
            bus.hall = 3'b010;
            tick(8);
         end else tick(20);
         prev = codes[i];
      end

      // Reverse: coast CC cycles, then reverse map with ramp from 0
      n = cyc; bus.direction = 1'b1;
      expect_at(n + 2,          "pre_coast", model(3'b101, 1'b0, 20, 1'b1, 1'b0, 2'b00, 5), M_ALL);
      expect_at(n + 3,          "coast",     model(3'b101, 1'b1, 0,  1'b0, 1'b0, 2'b00, 5), M_ALL);
      expect_at(n + 2 + CC,     "coast_end", model(3'b101, 1'b1, 0,  1'b0, 1'b0, 2'b00, 5), M_ALL);
      expect_at(n + 3 + CC,     "rev_run",   model(3'b101, 1'b1, 0,  1'b1, 1'b0, 2'b00, 5), M_ALL);
      expect_at(n + 42 + CC,    "rev_ramp",  model(3'b101, 1'b1, 10, 1'b1, 1'b0, 2'b00, 5), M_ALL);
      expect_at(n + 123 + CC,   "rev_full",  model(3'b101, 1'b1, 20, 1'b1, 1'b0, 2'b00, 5), M_ALL);
      tick(CC + 130);

      // Direction change during coast restarts the coast count
      p = cyc; bus.direction = 1'b0;
      expect_at(p + 3, "coast2", model(3'b101, 1'b1, 0, 1'b0, 1'b0, 2'b00, 5), M_ALL);
      tick(10);
      bus.direction = 1'b1;
      expect_at(p + 12 + CC,  "restart_hold", model(3'b101, 1'b1, 0,  1'b0, 1'b0, 2'b00, 5), M_ALL);
      expect_at(p + 13 + CC,  "restart_run",  model(3'b101, 1'b1, 0,  1'b1, 1'b0, 2'b00, 5), M_ALL);
      expect_at(p + 113 + CC, "restart_full", model(3'b101, 1'b1, 20, 1'b1, 1'b0, 2'b00, 5), M_ALL);
      tick(CC + 110);

      // Invalid hall code latches fault 01 until enable drops
      n = cyc; bus.hall = 3'b111;
      expect_at(n + 6,  "pre_fault",  model(3'b101, 1'b1, 20, 1'b1, 1'b0, 2'b00, 5), M_ALL);
      expect_at(n + 7,  "fault_inv",  model(3'b111, 1'b1, 0,  1'b0, 1'b1, 2'b01, 5), M_ALL);
      expect_at(n + 60, "fault_hold", model(3'b111, 1'b1, 0,  1'b0, 1'b1, 2'b01, 5), M_ALL);
      expect_at(n + 80, "fault_ok_h", model(3'b001, 1'b1, 0,  1'b0, 1'b1, 2'b01, 5), M_ALL);
      tick(60);
      bus.hall = 3'b001;
      tick(25);
      q = cyc; bus.enable = 1'b0;
      expect_at(q + 2, "fault_late", model(3'b001, 1'b1, 0, 1'b0, 1'b1, 2'b01, 5), M_ALL);
      expect_at(q + 3, "idle_clear", model(3'b001, 1'b1, 0, 1'b0, 1'b0, 2'b00, 5), M_ALL);
      tick(10);

      // Frozen hall with duty 50
      n = cyc; bus.duty_cmd = 50; bus.enable = 1'b1; e = n + 3;
      expect_at(e, "stall_entry", model(3'b001, 1'b1, 0, 1'b1, 1'b0, 2'b00, 5), M_ALL);
`ifdef STALL_DETECT_EN
      expect_at(e + 900,  "stall_early", model(3'b001, 1'b1, 50, 1'b1, 1'b0, 2'b00, 5), M_ALL);
      expect_at(e + 1010, "stall_fault", model(3'b001, 1'b1, 0,  1'b0, 1'b1, 2'b10, 5), M_ALL);
      tick(1020);
`else
      expect_at(e + 1100, "no_stall", model(3'b001, 1'b1, 50, 1'b1, 1'b0, 2'b00, 5), M_ALL);
      tick(1110);
`endif
      bus.enable = 1'b0;
      tick(5);
      bus.duty_cmd = 0;
      n = cyc; bus.enable = 1'b1; e = n + 3;
      expect_at(e + 1100, "zero_duty", model(3'b001, 1'b1, 0, 1'b1, 1'b0, 2'b00, 5), M_ALL);
      tick(1110);

      n = 0;
      while (sb.size() > 0 && n < 100) begin tick(1); n++; end
      while (sb.size() > 0) begin
         exp_t it;
         it = sb.pop_front();
         check_eq(it.tag, VW'(cyc), VW'(it.due));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
